// File: rtl/norm_share_arb.sv
// norm_share_arb: round-robin share of one mantissa normalizer between requesters
module norm_share_arb #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 8,
    parameter int EXP_WIDTH     = 3,
    parameter int DECIMAL_POINT = 3,
    localparam int ID_WIDTH     = $clog2(NUM_REQ),
    localparam int LZC_WIDTH    = $clog2(WIDTH),
    localparam int ADJ_WIDTH    = EXP_WIDTH + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_mant_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [ID_WIDTH-1:0]      resp_id_o,
    output logic [WIDTH-1:0]         resp_mant_o,
    output logic [ADJ_WIDTH-1:0]     resp_exp_adj_o,
    output logic                     resp_zero_o
);
    logic                 can_accept, grant, found, lz_found, norm_zero;
    logic [ID_WIDTH-1:0]  prio_q, prio_d, gnt_id, idx;
    logic [WIDTH-1:0]     mant_arr [NUM_REQ];
    logic [WIDTH-1:0]     gnt_mant, norm_mant;
    logic [LZC_WIDTH-1:0] lzc;
    logic [ADJ_WIDTH-1:0] norm_adj;
    logic                 resp_valid_q, resp_valid_d, resp_zero_q, resp_zero_d;
    logic [ID_WIDTH-1:0]  resp_id_q, resp_id_d;
    logic [WIDTH-1:0]     resp_mant_q, resp_mant_d;
    logic [ADJ_WIDTH-1:0] resp_adj_q, resp_adj_d;

    // Unpack the flat mantissa bus into one entry per requester.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) mant_arr[k] = req_mant_i[k*WIDTH +: WIDTH];
    end

    // Scan from the priority pointer with wrap-around; first valid requester wins.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_WIDTH'((32'(prio_q) + 32'(k)) % NUM_REQ);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
    end

    assign gnt_mant = mant_arr[gnt_id];

    // Leading-zero count, shift-up and exponent adjust of the granted mantissa.
    always_comb begin
        lz_found = 1'b0;
        lzc      = '0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            if (!lz_found && gnt_mant[b]) begin
                lz_found = 1'b1;
                lzc      = LZC_WIDTH'(WIDTH - 1 - b);
            end
        end
        norm_zero = ~|gnt_mant;
        norm_mant = gnt_mant << lzc;
        norm_adj  = norm_zero ? '0 : ADJ_WIDTH'(DECIMAL_POINT - 1 - 32'(lzc));
    end

    assign can_accept  = !resp_valid_q || resp_ready_i;
    assign grant       = !rst_i && can_accept && found;
    assign req_ready_o = grant ? NUM_REQ'(1) << gnt_id : '0;

    // Load on grant (also covers handshake plus grant), clear valid on a bare handshake.
    always_comb begin
        prio_d       = prio_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_mant_d  = resp_mant_q;
        resp_adj_d   = resp_adj_q;
        resp_zero_d  = resp_zero_q;
        if (grant) begin
            prio_d       = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            resp_valid_d = 1'b1;
            resp_id_d    = gnt_id;
            resp_mant_d  = norm_mant;
            resp_adj_d   = norm_adj;
            resp_zero_d  = norm_zero;
        end else if (resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_mant_q  <= '0;
            resp_adj_q   <= '0;
            resp_zero_q  <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_mant_q  <= resp_mant_d;
            resp_adj_q   <= resp_adj_d;
            resp_zero_q  <= resp_zero_d;
        end
    end

    assign resp_valid_o   = resp_valid_q;
    assign resp_id_o      = resp_id_q;
    assign resp_mant_o    = resp_mant_q;
    assign resp_exp_adj_o = resp_adj_q;
    assign resp_zero_o    = resp_zero_q;
endmodule

// File: tb/tb_norm_share_arb.sv
// tb_norm_share_arb: directed and random checks of norm_share_arb against a reference model
module tb_norm_share_arb;
    localparam int N  = 4;
    localparam int DP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  req_ready_o;
    logic [31:0] mant;
    logic        rdy;
    logic        resp_valid_o, resp_zero_o;
    logic [1:0]  resp_id_o;
    logic [7:0]  resp_mant_o;
    logic [3:0]  resp_exp_adj_o;

    int          total = 0, bad = 0;
    logic [3:0]  granted;
    int          mprio;
    logic        mv, mz;
    logic [1:0]  mid;
    logic [7:0]  mm;
    logic [3:0]  madj;
    int          order_q [$];

    norm_share_arb dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(vld), .req_ready_o(req_ready_o),
        .req_mant_i(mant), .resp_valid_o(resp_valid_o), .resp_ready_i(rdy),
        .resp_id_o(resp_id_o), .resp_mant_o(resp_mant_o),
        .resp_exp_adj_o(resp_exp_adj_o), .resp_zero_o(resp_zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference normalization: double the value until its top bit is set.
    task automatic norm(input logic [7:0] m, output logic [7:0] om, output logic [3:0] adj, output logic z);
        int v, l;
        v = int'(m);
        l = 0;
        if (v == 0) begin
            om = 0; adj = 0; z = 1'b1;
        end else begin
            while (v < 128) begin
                v = v * 2;
                l++;
            end
            om = 8'(v); adj = 4'(DP - 1 - l); z = 1'b0;
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mprio + k) % N;
            if (vld[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        int g;
        logic gr;
        logic [3:0] exp_rdy;
        @(negedge clk);
        g = pick();
        gr = !rst && (!mv || rdy) && (g >= 0);
        exp_rdy = gr ? 4'(1 << g) : 4'b0;
        chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
        chk("resp_valid", 32'(resp_valid_o), 32'(mv));
        chk("resp_id", 32'(resp_id_o), 32'(mid));
        chk("resp_mant", 32'(resp_mant_o), 32'(mm));
        chk("resp_adj", 32'(resp_exp_adj_o), 32'(madj));
        chk("resp_zero", 32'(resp_zero_o), 32'(mz));
        if (!rst && resp_valid_o && rdy) begin
            if (order_q.size() == 0) chk("order_underflow", 32'(order_q.size()), 32'd1);
            else chk("order_id", 32'(resp_id_o), 32'(order_q.pop_front()));
        end
        granted = req_ready_o;
        @(posedge clk);
        if (rst) begin
            mv = 0; mid = 0; mm = 0; madj = 0; mz = 0; mprio = 0;
            order_q.delete();
        end else if (gr) begin
            mid = 2'(g);
            norm(mant[g*8 +: 8], mm, madj, mz);
            mv = 1;
            mprio = (g + 1) % N;
            order_q.push_back(g);
        end else if (rdy) begin
            mv = 0;
        end
        #1;
    endtask

    logic [7:0] corner_in  [3] = '{8'h80, 8'h01, 8'h00};
    logic [7:0] corner_m   [3] = '{8'h80, 8'h80, 8'h00};
    logic [3:0] corner_adj [3] = '{4'h2, 4'hB, 4'h0};
    logic [1:0] held;

    initial begin
        mv = 0; mid = 0; mm = 0; madj = 0; mz = 0; mprio = 0;
        rst = 1; vld = 0; mant = 0; rdy = 1;
        @(posedge clk); #1;
        step();
        chk("reset_valid", 32'(resp_valid_o), 32'd0);
        rst = 0;

        // round robin with all requesters valid
        vld = 4'hF;
        for (int i = 0; i < N; i++) mant[i*8 +: 8] = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_id", 32'(resp_id_o), 32'(k % N));
            for (int i = 0; i < N; i++) if (granted[i]) mant[i*8 +: 8] = 8'($urandom);
        end

        // requester 1 alone, re-granted right after its own grant
        vld = 4'b0010;
        step();
        chk("solo1_a", 32'(granted), 32'b0010);
        step();
        chk("solo1_b", 32'(granted), 32'b0010);

        // single request from requester 2
        vld = 4'b0100; mant[16 +: 8] = 8'h16;
        step();
        chk("single_id", 32'(resp_id_o), 32'd2);
        chk("single_mant", 32'(resp_mant_o), 32'hB0);
        chk("single_adj", 32'(resp_exp_adj_o), 32'hF);
        chk("single_zero", 32'(resp_zero_o), 32'd0);

        // normalization corners through requester 0
        for (int c = 0; c < 3; c++) begin
            vld = 4'b0001; mant[7:0] = corner_in[c];
            step();
            chk("corner_mant", 32'(resp_mant_o), 32'(corner_m[c]));
            chk("corner_adj", 32'(resp_exp_adj_o), 32'(corner_adj[c]));
            chk("corner_zero", 32'(resp_zero_o), 32'(corner_in[c] == 0));
        end

        // backpressure with requesters 0 and 3 waiting
        rdy = 0; vld = 4'b1001; mant[7:0] = 8'h3C; mant[31:24] = 8'h05;
        held = resp_id_o;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_ready", 32'(granted), 32'd0);
            chk("bp_hold_id", 32'(resp_id_o), 32'(held));
        end
        rdy = 1;
        step();
        chk("bp_release", 32'(granted), 32'b1000);
        chk("bp_new_id", 32'(resp_id_o), 32'd3);
        vld[3] = 0;
        step();
        chk("bp_next", 32'(granted), 32'b0001);

        // reset while a response is pending and prio is 2
        vld = 4'b0010;
        step();
        rst = 1; rdy = 0; vld = 0;
        step();
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_data", {resp_id_o, resp_mant_o, resp_exp_adj_o, resp_zero_o}, 32'd0);
        rst = 0; rdy = 1; vld = 4'b1010;
        step();
        chk("rst_first", 32'(granted), 32'b0010);
        vld = 0;

        // random mix
        for (int k = 0; k < 3000; k++) begin
            rdy = ($urandom % 4) != 0;
            rst = ($urandom % 200) == 0;
            step();
            for (int i = 0; i < N; i++) begin
                if (granted[i] || !vld[i]) begin
                    vld[i] = ($urandom % 3) != 0;
                    mant[i*8 +: 8] = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom) >> ($urandom % 8);
                end
            end
        end
        rst = 0; vld = 0; rdy = 1;
        step();
        step();
        chk("drain_valid", 32'(resp_valid_o), 32'd0);
        chk("drain_order", 32'(order_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
